// File: rtl/keypad_field_entry_if.sv
// Request/result channel between the keypad entry block and the downstream classifier.
// The entry block owns the master side; the classifier owns the slave side.
interface keypad_field_entry_if #(
    parameter int N_FIELDS = 7,
    parameter int VAL_W    = 14,
    parameter int RES_W    = 4
);
    logic [N_FIELDS*VAL_W-1:0] fields_flat;
    logic                      req_valid;
    logic                      req_ready;
    logic                      res_valid;
    logic [RES_W-1:0]          res_data;

    modport master (
        output fields_flat,
        output req_valid,
        input  req_ready,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  fields_flat,
        input  req_valid,
        output req_ready,
        output res_valid,
        output res_data
    );
endinterface

// File: rtl/keypad_field_entry.sv
// Keypad field entry: collects N_FIELDS decimal fields, hands them to a classifier
// and holds the classifier result for the 7-segment display path.
//
// state    | meaning
// ST_ENTRY | typing digits into field field_q
// ST_REQ   | all fields committed, req_valid high until the classifier accepts
// ST_WAIT  | request accepted, waiting for the res_valid strobe
// ST_SHOW  | result latched and displayed; next key starts over
module keypad_field_entry #(
    parameter int N_FIELDS = 7,
    parameter int N_DIGITS = 4,
    parameter int VAL_W    = 14,
    parameter int RES_W    = 4,
    localparam int FW      = $clog2(N_FIELDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [9:0]            key_i,
    input  logic                  key_clear_i,
    input  logic                  key_next_i,
    input  logic                  key_back_i,
    output logic [FW-1:0]         field_sel_o,
    output logic [4*N_DIGITS-1:0] disp_bcd_o,
    output logic                  busy_o,
    keypad_field_entry_if.master  cls_if
);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int BW = 4 * N_DIGITS;

    typedef enum logic [1:0] {ST_ENTRY, ST_REQ, ST_WAIT, ST_SHOW} state_e;

    state_e                    state_q, state_d;
    logic [9:0]                key_q;
    logic                      clear_q, next_q, back_q;
    logic [BW-1:0]             bcd_q, bcd_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [FW-1:0]             field_q, field_d;
    logic [N_FIELDS*VAL_W-1:0] fields_q, fields_d;
    logic [RES_W-1:0]          res_q, res_d;

    logic [9:0]       dig_edge;
    logic             clear_e, next_e, back_e;
    logic             dig_hit;
    logic [3:0]       dig_val;
    logic [VAL_W-1:0] bin;
    logic             do_clear;

    assign dig_edge = key_i & ~key_q;
    assign clear_e  = key_clear_i & ~clear_q;
    assign next_e   = key_next_i & ~next_q;
    assign back_e   = key_back_i & ~back_q;

    // Scan from the top so the lowest simultaneous digit is the one that sticks.
    always_comb begin
        dig_hit = 1'b0;
        dig_val = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (dig_edge[k]) begin
                dig_hit = 1'b1;
                dig_val = 4'(k);
            end
        end
    end

    always_comb begin
        bin = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            bin = VAL_W'(bin * VAL_W'(10)) + VAL_W'(bcd_q[4*k +: 4]);
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        field_d  = field_q;
        fields_d = fields_q;
        res_d    = res_q;
        do_clear = clear_e;

        case (state_q)
            ST_ENTRY: begin
                if (next_e) begin
                    for (int i = 0; i < N_FIELDS; i++) begin
                        if (field_q == FW'(i)) begin
                            fields_d[i*VAL_W +: VAL_W] = bin;
                        end
                    end
                    bcd_d = '0;
                    cnt_d = '0;
                    if (field_q < FW'(N_FIELDS - 1)) begin
                        field_d = field_q + 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (back_e) begin
                    if (cnt_q != '0) begin
                        bcd_d = bcd_q >> 4;
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (dig_hit) begin
                    if (cnt_q < CW'(N_DIGITS)) begin
                        bcd_d = {bcd_q[BW-5:0], dig_val};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (cls_if.req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cls_if.res_valid) begin
                    res_d   = cls_if.res_data;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (next_e) begin
                    do_clear = 1'b1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase

        // Clear (or next out of SHOW) overrides anything decided above.
        if (do_clear) begin
            state_d  = ST_ENTRY;
            bcd_d    = '0;
            cnt_d    = '0;
            field_d  = '0;
            fields_d = '0;
            res_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_ENTRY;
            key_q    <= '0;
            clear_q  <= 1'b0;
            next_q   <= 1'b0;
            back_q   <= 1'b0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            field_q  <= '0;
            fields_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_i;
            clear_q  <= key_clear_i;
            next_q   <= key_next_i;
            back_q   <= key_back_i;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            field_q  <= field_d;
            fields_q <= fields_d;
            res_q    <= res_d;
        end
    end

    assign field_sel_o        = (state_q == ST_SHOW) ? FW'(N_FIELDS) : field_q;
    assign disp_bcd_o         = (state_q == ST_SHOW) ? {{(BW-RES_W){1'b0}}, res_q} : bcd_q;
    assign busy_o             = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign cls_if.req_valid   = (state_q == ST_REQ);
    assign cls_if.fields_flat = fields_q;
endmodule

// File: tb/tb_keypad_field_entry.sv
// Directed bench for keypad_field_entry: expected outputs are queued as each step is
// driven and popped for comparison once the DUT has had its cycle to respond.
module tb_keypad_field_entry;
    localparam int NF = 7;
    localparam int ND = 4;
    localparam int VW = 14;
    localparam int RW = 4;
    localparam int FW = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [9:0]      key_i;
    logic            key_clear_i, key_next_i, key_back_i;
    logic [FW-1:0]   field_sel_o;
    logic [4*ND-1:0] disp_bcd_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    keypad_field_entry_if #(.N_FIELDS(NF), .VAL_W(VW), .RES_W(RW)) cls_if ();

    keypad_field_entry #(
        .N_FIELDS(NF), .N_DIGITS(ND), .VAL_W(VW), .RES_W(RW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_i       (key_i),
        .key_clear_i (key_clear_i),
        .key_next_i  (key_next_i),
        .key_back_i  (key_back_i),
        .field_sel_o (field_sel_o),
        .disp_bcd_o  (disp_bcd_o),
        .busy_o      (busy_o),
        .cls_if      (cls_if)
    );

    typedef struct {
        string             tag;
        logic [FW-1:0]     sel;
        logic [4*ND-1:0]   disp;
        logic              rv;
        logic              busy;
        logic [NF*VW-1:0]  flat;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned mf[NF];
    int          total = 0;
    int          bad   = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [15:0] disp,
                            input logic rv, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.sel  = FW'(sel);
        e.disp = disp;
        e.rv   = rv;
        e.busy = busy;
        e.flat = '0;
        for (int i = 0; i < NF; i++) e.flat[i*VW +: VW] = VW'(mf[i]);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string what, input logic [127:0] obs,
                       input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, "field_sel", 128'(field_sel_o), 128'(e.sel));
            chk(e.tag, "disp_bcd", 128'(disp_bcd_o), 128'(e.disp));
            chk(e.tag, "req_valid", 128'(cls_if.req_valid), 128'(e.rv));
            chk(e.tag, "busy", 128'(busy_o), 128'(e.busy));
            chk(e.tag, "fields_flat", 128'(cls_if.fields_flat), 128'(e.flat));
        end
    endtask

    task automatic press(input logic [9:0] k, input logic c, input logic n, input logic b);
        key_i       = k;
        key_clear_i = c;
        key_next_i  = n;
        key_back_i  = b;
        tick();
        key_i       = '0;
        key_clear_i = 1'b0;
        key_next_i  = 1'b0;
        key_back_i  = 1'b0;
        tick();
    endtask

    task automatic digit(input int d);
        logic [9:0] m;
        m = 10'b1;
        press(m << d, 1'b0, 1'b0, 1'b0);
    endtask

    // Commits field i with the value (i+off)%9+1, typed with a leading zero.
    task automatic fill_all(input int off);
        int v;
        for (int i = 0; i < NF; i++) begin
            v = (i + off) % 9 + 1;
            digit(0);
            digit(v);
            press('0, 1'b0, 1'b1, 1'b0);
            mf[i] = v;
            if (i < NF - 1) push_exp("fill", i + 1, 16'h0000, 1'b0, 1'b0);
            else            push_exp("fill_last", NF - 1, 16'h0000, 1'b1, 1'b1);
            check_out();
        end
    endtask

    initial begin
        rst_ni             = 1'b0;
        key_i              = '0;
        key_clear_i        = 1'b0;
        key_next_i         = 1'b0;
        key_back_i         = 1'b0;
        cls_if.req_ready   = 1'b0;
        cls_if.res_valid   = 1'b0;
        cls_if.res_data    = '0;
        for (int i = 0; i < NF; i++) mf[i] = 0;
        tick();
        tick();
        push_exp("reset", 0, 16'h0000, 1'b0, 1'b0);
        check_out();
        rst_ni = 1'b1;
        tick();

        digit(1); digit(2); digit(3);
        push_exp("d123", 0, 16'h0123, 1'b0, 1'b0);
        check_out();
        press('0, 1'b0, 1'b1, 1'b0);
        mf[0] = 123;
        push_exp("commit0", 1, 16'h0000, 1'b0, 1'b0);
        check_out();

        digit(9); digit(9); digit(9); digit(9); digit(5);
        push_exp("saturate", 1, 16'h9999, 1'b0, 1'b0);
        check_out();
        press('0, 1'b0, 1'b0, 1'b1);
        press('0, 1'b0, 1'b0, 1'b1);
        push_exp("back2", 1, 16'h0099, 1'b0, 1'b0);
        check_out();
        for (int i = 0; i < 3; i++) press('0, 1'b0, 1'b0, 1'b1);
        push_exp("back_underflow", 1, 16'h0000, 1'b0, 1'b0);
        check_out();

        key_i = 10'b00_0001_0000;
        repeat (20) tick();
        key_i = '0;
        tick();
        push_exp("held", 1, 16'h0004, 1'b0, 1'b0);
        check_out();

        press(10'b00_1000_1000, 1'b0, 1'b0, 1'b1);
        push_exp("back_prio", 1, 16'h0000, 1'b0, 1'b0);
        check_out();
        press(10'b00_1000_1000, 1'b0, 1'b0, 1'b0);
        push_exp("low_digit", 1, 16'h0003, 1'b0, 1'b0);
        check_out();
        press('0, 1'b0, 1'b1, 1'b0);
        mf[1] = 3;
        digit(4); digit(2);
        press('0, 1'b0, 1'b1, 1'b0);
        mf[2] = 42;
        digit(5);
        push_exp("field3", 3, 16'h0005, 1'b0, 1'b0);
        check_out();

        rst_ni = 1'b0;
        tick();
        for (int i = 0; i < NF; i++) mf[i] = 0;
        push_exp("mid_reset", 0, 16'h0000, 1'b0, 1'b0);
        check_out();
        rst_ni = 1'b1;
        tick();

        fill_all(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            push_exp("req_hold", NF - 1, 16'h0000, 1'b1, 1'b1);
            check_out();
        end

        cls_if.req_ready = 1'b1;
        cls_if.res_valid = 1'b1;
        cls_if.res_data  = 4'd5;
        tick();
        cls_if.req_ready = 1'b0;
        cls_if.res_valid = 1'b0;
        push_exp("handshake", NF - 1, 16'h0000, 1'b0, 1'b1);
        check_out();
        digit(8);
        push_exp("wait_digit", NF - 1, 16'h0000, 1'b0, 1'b1);
        check_out();

        cls_if.res_valid = 1'b1;
        cls_if.res_data  = 4'd1;
        tick();
        cls_if.res_valid = 1'b0;
        cls_if.res_data  = 4'd0;
        push_exp("show", NF, 16'h0001, 1'b0, 1'b0);
        check_out();
        press('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NF; i++) mf[i] = 0;
        push_exp("show_next", 0, 16'h0000, 1'b0, 1'b0);
        check_out();

        fill_all(3);
        press('0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NF; i++) mf[i] = 0;
        push_exp("clear_req", 0, 16'h0000, 1'b0, 1'b0);
        check_out();

        cls_if.res_valid = 1'b1;
        cls_if.res_data  = 4'd9;
        tick();
        cls_if.res_valid = 1'b0;
        digit(6);
        push_exp("res_ignored", 0, 16'h0006, 1'b0, 1'b0);
        check_out();

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_field_entry.md
# keypad_field_entry

Parametrised, clocked successor to the combinational-trigger keypad entry block: collects `N_FIELDS` decimal fields of up to `N_DIGITS` digits each from a one-hot digit keypad plus clear/next/back keys. It converts each committed field to binary and presents all fields to a downstream classifier over a valid/ready request. It then waits for the classifier's result and holds it for the 7-segment display path (existing `bcd7seg` decoders sit downstream of `disp_bcd` / `field_sel`).

## Interface
- `N_FIELDS`, 7, number of input fields (field index width `FW = clog2(N_FIELDS+1)`)
- `N_DIGITS`, 4, max decimal digits per field
- `VAL_W`, 14, binary width per field; must hold 10^N_DIGITS − 1
- `RES_W`, 4, classifier result width (≤ 4, shown as one BCD digit)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `key`  in  10  digit keys, bit k = digit k, level (switch/button)
- `key_clear`  in  1  clear-all key, level
- `key_next`  in  1  commit field / advance, level
- `key_back`  in  1  delete last digit of current field, level
- `field_sel`  out  FW  current field index; `N_FIELDS` while showing result
- `disp_bcd`  out  4*N_DIGITS  BCD digits of current field, digit 0 = least significant
- `fields_flat`  out  N_FIELDS*VAL_W  committed binary values, field i at bits [i*VAL_W +: VAL_W]
- `req_valid`  out  1  fields_flat complete, request classification
- `req_ready`  in  1  classifier accepts request
- `res_valid`  in  1  classifier result strobe (one cycle)
- `res_data`  in  RES_W  classifier result
- `busy`  out  1  high in REQ or WAIT

## Operation
- Edge detect: every key input registered once; an action fires on the cycle where input = 1 and its registered copy = 0. Holding a key produces one action.
- Priority on the same cycle: clear > next > back > digit. Several digit edges together: lowest index wins.
- States: ENTRY, REQ, WAIT, SHOW.
- ENTRY, digit d: if count < N_DIGITS, BCD shifts left (digit0 ← d), count+1. Else ignored (saturate, no wrap). Leading zeros count as digits.
- ENTRY, back: if count > 0, BCD shifts right (top digit ← 0), count−1. Else no-op.
- ENTRY, next: field value = Σ digit_k·10^k written to `fields_flat` slot. BCD/count cleared. If field_sel < N_FIELDS−1, field_sel+1. Else → REQ.
- REQ: `req_valid`=1. Transfer on the cycle `req_valid && req_ready` → WAIT.
- WAIT: on `res_valid`, latch `res_data` → SHOW. `res_valid` outside WAIT is ignored.
- SHOW: `field_sel` = N_FIELDS. `disp_bcd` digit0 = result, other digits 0. next → full clear.
- Digit/back/next in REQ and WAIT are ignored; back/digit in SHOW are ignored.
- Clear (any state): state ENTRY, field_sel 0, all BCD, counts, fields_flat and result zeroed, `req_valid` drops next cycle (request abort is permitted).
- `disp_bcd` in ENTRY shows the live BCD of the current field. Previously committed fields are not re-editable.

## Timing
- Reset (rst_n=0 at a clock edge): state ENTRY, field_sel 0, disp_bcd 0, fields_flat 0, req_valid 0, busy 0, edge registers 0 (a key held through reset release fires one action on the first cycle out of reset).
- Key press to display update: input seen high at edge n+1 (registered copy still 0) → outputs updated after edge n+1, i.e. 1 cycle after sampling.
- Last next → req_valid high the following cycle. req_valid held until handshake. busy is updated with the state register.
- Handshake at edge m → WAIT from m; res_valid at the same edge m is ignored (must come in WAIT).
- res_valid at edge r → SHOW and result visible after r.
- Binary conversion is combinational off the BCD registers and registered at the commit edge (no multi-cycle latency).

## Test plan
- Reset, press 1,2,3 → disp_bcd = 0x0123, field_sel 0. Press next → fields_flat[0] = 123, disp_bcd 0, field_sel 1.
- Type 9,9,9,9,5 → fifth digit ignored, disp 0x9999. back ×2 → 0x0099. back ×3 → 0x0000 with no underflow. Held key for 20 cycles → one digit.
- Same cycle: key[3], key[7], key_back → back only. key[3]|key[7] alone → digit 3.
- Fill 7 fields (values 1..7), last next → req_valid=1, busy=1. req_ready held low 5 cycles → req_valid held. Raise ready → WAIT. res_valid with res_data=1 → field_sel 7, disp_bcd 0x0001. next → all zeros, field_sel 0.
- key_clear mid-REQ → req_valid 0 next cycle, fields_flat 0. Digit pressed in WAIT → no change.
- rst_n low during field 3 entry → every output at reset value next cycle.
